// File: rtl/mem_block_copier_pkg.sv
// Shared definitions for the block copier: FSM state encoding and default geometry
// of the attached DataMemory.
package mem_block_copier_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 32;
  localparam int MEM_DEPTH  = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_WRITE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mem_block_copier.sv
// Bus-initiator that copies a block of words inside DataMemory, choosing copy
// direction so overlapping regions are handled, and accumulates a wrapping checksum.
module mem_block_copier
  import mem_block_copier_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [ADDR_W:0]   Length,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Sum,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] WriteData,
  output logic              MemoryRead,
  output logic              MemoryWrite,
  input  logic [DATA_W-1:0] ReadData
);

  localparam int unsigned DEPTH   = (ADDR_W == DEF_ADDR_W) ? MEM_DEPTH : (1 << ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  // Copy backward when the destination starts inside the source block (circularly),
  // so no source word is overwritten before it has been read.
  function automatic logic is_backward(input logic [ADDR_W-1:0] src,
                                       input logic [ADDR_W-1:0] dst,
                                       input logic [ADDR_W:0]   len);
    logic [ADDR_W-1:0] diff;
    diff = dst - src;
    return (dst != src) && ({1'b0, diff} < len);
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                bwd_q, bwd_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [ADDR_W:0]     len_c;
  logic [ADDR_W-1:0]   off;
  logic                start_bwd;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    bwd_d     = bwd_q;
    sum_d     = sum_q;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    len_c     = (Length > DEPTH_L) ? DEPTH_L : Length;
    off       = len_c[ADDR_W-1:0] - 1'b1;
    start_bwd = is_backward(SrcAddr, DstAddr, len_c);

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          cnt_d = len_c;
          sum_d = '0;
          bwd_d = start_bwd;
          src_d = start_bwd ? SrcAddr + off : SrcAddr;
          dst_d = start_bwd ? DstAddr + off : DstAddr;
          state_d = (len_c == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ:    state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        sum_d   = sum_q + ReadData;
        wdata_d = ReadData;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        src_d   = bwd_q ? src_q - 1'b1 : src_q + 1'b1;
        dst_d   = bwd_q ? dst_q - 1'b1 : dst_q + 1'b1;
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == (ADDR_W + 1)'(1)) ? ST_DONE : ST_READ;
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Bus outputs are registered, so they are derived from the state being entered.
    case (state_d)
      ST_READ: begin
        rd_d   = 1'b1;
        addr_d = src_d;
      end
      ST_WRITE: begin
        wr_d   = 1'b1;
        addr_d = dst_d;
      end
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      bwd_q   <= 1'b0;
      sum_q   <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      bwd_q   <= bwd_d;
      sum_q   <= sum_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Sum         = sum_q;
  assign MemAddress  = addr_q;
  assign WriteData   = wdata_q;
  assign MemoryRead  = rd_q;
  assign MemoryWrite = wr_q;

endmodule
